// File: rtl/int_arb_pkg.sv
// Shared types and default sizing for the integer stream arbiter family.
package int_arb_pkg;

  // Default sizing used by system tops that do not override the parameters.
  localparam int DEF_NUM_IN = 4;
  localparam int DEF_BURST  = 4;
  localparam int DEF_ID_W   = $clog2(DEF_NUM_IN);
  localparam int CNT_W      = 32;

  // Source index of a word, sized for the default input count.
  typedef logic [DEF_ID_W-1:0] src_id_t;

  // Per-input transfer counter; wraps naturally at 2^32.
  typedef logic [CNT_W-1:0] cnt_t;

endpackage

// File: rtl/int_rr_pick.sv
// Cyclic first-set search: finds the first asserted request after ptr,
// wrapping around so that ptr itself is considered last.
module int_rr_pick #(
  parameter int NUM_IN = 4,
  parameter int ID_W   = $clog2(NUM_IN)
) (
  input  logic [NUM_IN-1:0] req,
  input  logic [ID_W-1:0]   ptr,
  output logic [ID_W-1:0]   gnt_idx,
  output logic              any
);

  function automatic logic [ID_W-1:0] wrap_idx(input int base, input int step);
    return ID_W'((base + step) % NUM_IN);
  endfunction

  // Walk the candidates from furthest to nearest so the nearest asserted
  // request (starting at ptr+1) is the one that survives.
  always_comb begin
    gnt_idx = '0;
    any     = |req;
    for (int k = NUM_IN; k >= 1; k--) begin
      if (req[wrap_idx(int'(ptr), k)]) begin
        gnt_idx = wrap_idx(int'(ptr), k);
      end
    end
  end

endmodule

// File: rtl/int_stream_rr_arbiter.sv
// Round-robin arbiter with bounded bursts that merges NUM_IN valid/ready
// integer streams into one registered output carrying the source index,
// and keeps a wrapping transfer counter per input.
module int_stream_rr_arbiter
  import int_arb_pkg::*;
#(
  parameter  int NUM_IN = DEF_NUM_IN,
  parameter  int WIDTH  = 32,
  parameter  int BURST  = DEF_BURST,
  localparam int ID_W   = $clog2(NUM_IN)
) (
  input  logic                    clk,
  input  logic                    rstn,
  input  logic [NUM_IN-1:0]       in_valid,
  input  logic [NUM_IN*WIDTH-1:0] in_data,
  output logic [NUM_IN-1:0]       in_ready,
  output logic                    out_valid,
  output logic [WIDTH-1:0]        out_data,
  output logic [ID_W-1:0]         out_id,
  input  logic                    out_ready,
  output logic [NUM_IN*CNT_W-1:0] xfer_cnt
);

  localparam int BW = $clog2(BURST + 1);

  logic [ID_W-1:0]  owner;
  logic [BW-1:0]    burst_cnt;
  logic [ID_W-1:0]  pick_idx;
  logic             pick_any;
  logic [ID_W-1:0]  grant;
  logic             keep;
  logic             load_ok;
  logic             xfer;
  logic [WIDTH-1:0] in_word [NUM_IN];

  for (genvar i = 0; i < NUM_IN; i++) begin : gen_word
    assign in_word[i] = in_data[i*WIDTH +: WIDTH];
  end

  int_rr_pick #(
    .NUM_IN (NUM_IN),
    .ID_W   (ID_W)
  ) u_pick (
    .req     (in_valid),
    .ptr     (owner),
    .gnt_idx (pick_idx),
    .any     (pick_any)
  );

  // The output register can take a new word when empty or draining this cycle.
  assign load_ok = !out_valid || out_ready;

  // A burst_cnt of zero only occurs after reset and means nobody owns the
  // stream yet, so the first grant comes from the cyclic search (input 0 first).
  assign keep  = in_valid[owner] && (burst_cnt != '0) && (burst_cnt < BW'(BURST));
  assign grant = keep ? owner : pick_idx;
  assign xfer  = |in_ready;

  // Ready goes only to the granted input, and never while in reset.
  always_comb begin
    in_ready = '0;
    if (rstn && load_ok && pick_any) begin
      in_ready[grant] = 1'b1;
    end
  end

  // Single-entry output register: load on a transfer, clear once drained.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_id    <= '0;
    end else if (load_ok) begin
      out_valid <= xfer;
      if (xfer) begin
        out_data <= in_word[grant];
        out_id   <= grant;
      end
    end
  end

  // Ownership and burst length; a new owner or an exhausted burst restarts at 1.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      owner     <= ID_W'(NUM_IN - 1);
      burst_cnt <= '0;
    end else if (xfer) begin
      if (keep) begin
        burst_cnt <= burst_cnt + BW'(1);
      end else begin
        owner     <= grant;
        burst_cnt <= BW'(1);
      end
    end
  end

  for (genvar i = 0; i < NUM_IN; i++) begin : gen_cnt
    cnt_t cnt_q;

    // Count accepted transfers on this input, wrapping at 2^32.
    always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
        cnt_q <= '0;
      end else if (in_valid[i] && in_ready[i]) begin
        cnt_q <= cnt_q + CNT_W'(1);
      end
    end

    assign xfer_cnt[i*CNT_W +: CNT_W] = cnt_q;
  end

endmodule

// File: tb/tb_int_stream_rr_arbiter.sv
// Scoreboard bench for int_stream_rr_arbiter: directed scenarios followed by
// random traffic, checked against a behavioural arbitration model.
module tb_int_stream_rr_arbiter;
  import int_arb_pkg::*;

  localparam int N   = 4;
  localparam int W   = 32;
  localparam int B   = 4;
  localparam int IDW = $clog2(N);

  logic           clk = 1'b0;
  logic           rstn;
  logic [N-1:0]   in_valid;
  logic [N*W-1:0] in_data;
  logic [N-1:0]   in_ready;
  logic           out_valid;
  logic [W-1:0]   out_data;
  logic [IDW-1:0] out_id;
  logic           out_ready;
  logic [N*32-1:0] xfer_cnt;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [W-1:0] data;
    int           id;
  } word_t;

  word_t sbq[$];

  int          mOwner;
  int          mBurst;
  bit          mFull;
  bit [31:0]   mCnt [N];
  int          mGrant;
  bit          mLoadOk;
  logic [N-1:0]    expReady;
  logic [N*32-1:0] expCnt;
  word_t       newWord;

  int_stream_rr_arbiter #(
    .NUM_IN (N),
    .WIDTH  (W),
    .BURST  (B)
  ) dut (
    .clk       (clk),
    .rstn      (rstn),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_id    (out_id),
    .out_ready (out_ready),
    .xfer_cnt  (xfer_cnt)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic modelReset();
    mOwner = N - 1;
    mBurst = 0;
    mFull  = 1'b0;
    for (int i = 0; i < N; i++) mCnt[i] = '0;
    sbq.delete();
  endtask

  // Keep the current owner while it is valid and its burst is live; otherwise
  // the nearest valid input after the owner wins, owner itself last.
  function automatic int pickGrant(input logic [N-1:0] v);
    if (mBurst > 0 && mBurst < B && v[mOwner]) return mOwner;
    for (int k = 1; k <= N; k++) begin
      if (v[(mOwner + k) % N]) return (mOwner + k) % N;
    end
    return -1;
  endfunction

  // Reference model: predicts ready, output occupancy and counters, and
  // pushes every accepted word into the scoreboard.
  always @(negedge clk) begin
    if (!rstn) begin
      checkOutput("ready_in_reset", 128'(in_ready), 128'(0));
      checkOutput("valid_in_reset", 128'(out_valid), 128'(0));
      modelReset();
    end else begin
      checkOutput("out_valid", 128'(out_valid), 128'(mFull));
      for (int i = 0; i < N; i++) expCnt[i*32 +: 32] = mCnt[i];
      checkOutput("xfer_cnt", 128'(xfer_cnt), 128'(expCnt));
      mLoadOk  = !mFull || out_ready;
      mGrant   = pickGrant(in_valid);
      expReady = '0;
      if (mLoadOk && mGrant >= 0) expReady[mGrant] = 1'b1;
      checkOutput("in_ready", 128'(in_ready), 128'(expReady));
      if (mLoadOk) begin
        mFull = (mGrant >= 0);
        if (mGrant >= 0) begin
          newWord.data = in_data[mGrant*W +: W];
          newWord.id   = mGrant;
          sbq.push_back(newWord);
          if (mGrant == mOwner && mBurst > 0 && mBurst < B) begin
            mBurst++;
          end else begin
            mOwner = mGrant;
            mBurst = 1;
          end
          mCnt[mGrant] = mCnt[mGrant] + 32'd1;
        end
      end
    end
  end

  // Output monitor: whatever the DUT presents must match the scoreboard head,
  // and stays compared every cycle until it drains.
  always @(negedge clk) begin
    if (rstn && out_valid) begin
      if (sbq.size() == 0) begin
        checkOutput("unexpected_out", 128'(out_valid), 128'(0));
      end else begin
        checkOutput("out_data", 128'(out_data), 128'(sbq[0].data));
        checkOutput("out_id", 128'(out_id), 128'(sbq[0].id));
        if (out_ready) void'(sbq.pop_front());
      end
    end
  end

  task automatic applyStimulus(input logic [N-1:0] v, input logic r);
    @(posedge clk);
    #1;
    in_valid  = v;
    out_ready = r;
    for (int i = 0; i < N; i++) in_data[i*W +: W] = $urandom;
  endtask

  initial begin
    rstn      = 1'b0;
    in_valid  = '1;
    out_ready = 1'b1;
    in_data   = '0;
    modelReset();
    repeat (3) @(posedge clk);
    #1 rstn = 1'b1;

    // Full contention, bursts of four per input.
    repeat (20) applyStimulus('1, 1'b1);

    // Sole requester across the burst boundary.
    repeat (10) applyStimulus(4'b0100, 1'b1);

    // Backpressure, then drain and load on the same edge.
    repeat (5) applyStimulus('1, 1'b0);
    repeat (2) applyStimulus(4'b0010, 1'b1);

    // Owner drops after two transfers, another input takes over.
    repeat (2) applyStimulus(4'b0001, 1'b1);
    repeat (3) applyStimulus(4'b1000, 1'b1);
    repeat (2) applyStimulus('0, 1'b1);

    // Counter wrap on input 1.
    @(posedge clk);
    #2 force dut.gen_cnt[1].cnt_q = 32'hFFFF_FFFF;
    #1 release dut.gen_cnt[1].cnt_q;
    mCnt[1] = 32'hFFFF_FFFF;
    applyStimulus(4'b0010, 1'b1);
    repeat (2) applyStimulus('0, 1'b1);

    // Asynchronous reset between edges while a word is held.
    repeat (3) applyStimulus('1, 1'b1);
    @(posedge clk);
    #2 rstn = 1'b0;
    #1;
    checkOutput("async_out_valid", 128'(out_valid), 128'(0));
    checkOutput("async_xfer_cnt", 128'(xfer_cnt), 128'(0));
    checkOutput("async_in_ready", 128'(in_ready), 128'(0));
    @(posedge clk);
    #1 rstn = 1'b1;
    repeat (4) applyStimulus('1, 1'b1);

    // Random traffic and random backpressure.
    for (int c = 0; c < 3000; c++) begin
      applyStimulus(N'($urandom), ($urandom_range(0, 3) != 0));
    end

    repeat (4) applyStimulus('0, 1'b1);
    @(negedge clk);
    checkOutput("scoreboard_drained", 128'(sbq.size()), 128'(0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
